// File: rtl/grid_pkg.sv
// Shared constants and state encoding for the grid cell-drawing sequencer.
package grid_pkg;

  localparam int GRID_COLS   = 40;
  localparam int GRID_ROWS   = 30;
  localparam int CELL_PIX    = 16;
  localparam int DRAW_CYCLES = 17;
  localparam int ADDR_W      = 6;
  localparam int ROW_W       = 5;
  localparam int STEP_W      = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_LOAD  = 3'd3,
    S_DRAW  = 3'd4,
    S_DONE  = 3'd5
  } draw_state_e;

endpackage

// File: rtl/grid_draw_ctrl_draw_step_counter.sv
// Step counter for one cell's DRAW phase: flags the first (k==0) and last (k==CYCLES-1) step.
module draw_step_counter
  import grid_pkg::*;
#(
  parameter int CYCLES = grid_pkg::DRAW_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic active,
  output logic first,
  output logic last
);

  localparam logic [STEP_W-1:0] TC_LOAD = STEP_W'(CYCLES - 1);

  // Down-counter holds the steps remaining; reloads whenever DRAW is not active.
  logic [STEP_W-1:0] remain;

  always_ff @(posedge clk) begin
    if (!reset_n || !active) begin
      remain <= TC_LOAD;
    end else if (remain != '0) begin
      remain <= remain - 1'b1;
    end
  end

  assign first = (remain == TC_LOAD);
  assign last  = (remain == '0);

endmodule

// File: rtl/grid_draw_ctrl.sv
// Frame sequencer: fetches one row word per grid row and steps the datapath through 4x4 cells.
//   state | meaning
//   IDLE  | waiting for start; addr/register hold last values
//   FETCH | one-cycle row_rd for row 'register'
//   WAIT  | waiting for row_valid from the row store
//   LOAD  | ld_x/ld_y/ld_c, clears datapath pixel counter
//   DRAW  | DRAW_CYCLES enable cycles, plot on all but the first
//   DONE  | one-cycle done pulse
module grid_draw_ctrl
  import grid_pkg::*;
#(
  parameter int COLS        = grid_pkg::GRID_COLS,
  parameter int ROWS        = grid_pkg::GRID_ROWS,
  parameter int DRAW_CYCLES = grid_pkg::DRAW_CYCLES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       row_rd,
  output logic [4:0] row_idx,
  input  logic       row_valid,
  output logic       ld_x,
  output logic       ld_y,
  output logic       ld_c,
  output logic       enable,
  output logic [4:0] register,
  output logic [5:0] addr,
  output logic       plot
);

  localparam logic [2:0] ST_IDLE  = S_IDLE;
  localparam logic [2:0] ST_FETCH = S_FETCH;
  localparam logic [2:0] ST_WAIT  = S_WAIT;
  localparam logic [2:0] ST_LOAD  = S_LOAD;
  localparam logic [2:0] ST_DRAW  = S_DRAW;
  localparam logic [2:0] ST_DONE  = S_DONE;

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);

  logic [2:0]        state, state_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [ROW_W-1:0]  reg_q, reg_nx;
  logic              ld_q;
  logic              step_first, step_last;
  logic              plot_nx;

  draw_step_counter #(.CYCLES(DRAW_CYCLES)) u_step (
    .clk     (clk),
    .reset_n (reset_n),
    .active  (state == ST_DRAW),
    .first   (step_first),
    .last    (step_last)
  );

  always_comb begin
    state_nx = state;
    addr_nx  = addr_q;
    reg_nx   = reg_q;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_FETCH;
          addr_nx  = '0;
          reg_nx   = '0;
        end
      end
      ST_FETCH: state_nx = ST_WAIT;
      ST_WAIT: begin
        if (row_valid) state_nx = ST_LOAD;
      end
      ST_LOAD: state_nx = ST_DRAW;
      ST_DRAW: begin
        if (step_last) begin
          if (addr_q != LAST_COL) begin
            addr_nx  = addr_q + 1'b1;
            state_nx = ST_LOAD;
          end else if (reg_q != LAST_ROW) begin
            addr_nx  = '0;
            reg_nx   = reg_q + 1'b1;
            state_nx = ST_FETCH;
          end else begin
            state_nx = ST_DONE;
          end
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Plot rises after the k==0 step and stays up until the last step of the cell.
  assign plot_nx = (state == ST_DRAW) && !step_last && (step_first || plot);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      reg_q  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      row_rd <= 1'b0;
      ld_q   <= 1'b0;
      enable <= 1'b0;
      plot   <= 1'b0;
    end else begin
      state  <= state_nx;
      addr_q <= addr_nx;
      reg_q  <= reg_nx;
      busy   <= (state_nx != ST_IDLE);
      done   <= (state_nx == ST_DONE);
      row_rd <= (state_nx == ST_FETCH);
      ld_q   <= (state_nx == ST_LOAD);
      enable <= (state_nx == ST_DRAW);
      plot   <= plot_nx;
    end
  end

  assign ld_x     = ld_q;
  assign ld_y     = ld_q;
  assign ld_c     = ld_q;
  assign addr     = addr_q;
  assign register = reg_q;
  assign row_idx  = reg_q;

endmodule

// File: doc/grid_draw_ctrl.md
Name: grid_draw_ctrl

Overview:
- Sequencer for the cell-drawing datapath: walks every cell of the COLS x ROWS life grid, fetches one 40-bit row word per grid row from the row store, and drives ld_x/ld_y/ld_c/enable/addr/register so the datapath emits 16 pixels (4x4 block) per cell.
- Generates the VGA plot strobe and frame start/busy/done handshake.
- Sits between the generation-update logic (start/done) and the datapath + VGA adapter.

Parameters:
- COLS, 40, cells per row; addr range 0..COLS-1; legal range 1..64.
- ROWS, 30, rows per frame; register range 0..ROWS-1; legal range 1..32.
- DRAW_CYCLES, 17, enable cycles per cell; matches the datapath pixel counter period 0..16.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  request one full-frame redraw; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on frame completion
- row_rd  out  1  one-cycle row fetch strobe
- row_idx  out  5  row being fetched; equals register
- row_valid  in  1  row word on datapath data input is valid; held until the next row_rd
- ld_x  out  1  datapath load x
- ld_y  out  1  datapath load y
- ld_c  out  1  datapath load colour
- enable  out  1  datapath pixel counter enable
- register  out  5  current row index
- addr  out  6  current column index
- plot  out  1  VGA write strobe

Behaviour:
- Reset (sync, reset_n=0 at clk edge), applied from any state:
  - state=IDLE.
  - All outputs 0, including register=0 and addr=0.
  - The in-flight draw is abandoned; no done pulse.
- States: IDLE, FETCH, WAIT, LOAD, DRAW, DONE. Registered Moore outputs; no combinational input-to-output paths.
- IDLE:
  - start=1 -> FETCH; register=0, addr=0.
  - start is ignored in every other state.
- FETCH:
  - row_rd=1 and row_idx=register for exactly this one cycle.
  - Unconditional -> WAIT.
- WAIT:
  - Stays until row_valid=1, then -> LOAD.
  - row_valid is sampled only in WAIT; the memory must respond 1 or more cycles after row_rd.
  - Stall length is unbounded.
- LOAD (1 cycle):
  - ld_x=ld_y=ld_c=1, which also clears the datapath pixel counter.
  - addr and register are stable through this cycle.
  - -> DRAW; internal step counter k=0.
- DRAW (exactly DRAW_CYCLES cycles, k=0..16):
  - enable=1 in every DRAW cycle.
  - plot=1 when k!=0, giving 16 plotted pixels with datapath offsets 0..15; plot=0 at k=0.
  - At k=16:
    - if addr!=COLS-1: addr+=1 -> LOAD.
    - else if register!=ROWS-1: addr=0, register+=1 -> FETCH.
    - else -> DONE.
- DONE: done=1 for one cycle, busy=1; -> IDLE.
- addr and register hold their last values in IDLE, except at reset.
- Timing (1-cycle memory latency): per cell 18 cycles; per row 2+COLS*18 = 722; frame 30*722+1 = 21661 cycles from the first FETCH through DONE inclusive.
- Strobe exclusivity:
  - ld_* and enable are never high together.
  - plot is never high outside DRAW.
  - row_rd is never high outside FETCH.

Decomposition:
- Shared package (grid_pkg): state enum, GRID_COLS=40, GRID_ROWS=30, CELL_PIX=16, DRAW_CYCLES=17, ADDR_W=6, ROW_W=5.
- One sub-module: draw_step_counter.
  - 5-bit, counts 0..DRAW_CYCLES-1 while DRAW is active.
  - Outputs last (k==16) and first (k==0).

Test Plan:
- Reset values: hold reset_n=0 three cycles -> all outputs 0, busy=0; start held during reset is ignored.
- Single frame, COLS=2, ROWS=2, row_valid one cycle after row_rd:
  - row_rd pulses at cycle offsets 0 and 38.
  - 4 LOAD pulses, 64 plot cycles total.
  - done at offset 76, then busy=0.
- Memory stall: row_valid delayed 10 cycles in WAIT -> no ld_*, enable or plot until row_valid; frame length grows by exactly 9 per row.
- Wrap at defaults:
  - addr goes 39->0 while register goes 0->1 at the k=16 edge.
  - Final cell is (39,29); done pulses once; total 21661 cycles.
- start asserted repeatedly while busy -> ignored; exactly one done; a new start in IDLE begins a fresh frame at register=0, addr=0.
- reset_n=0 mid-DRAW (k=7, addr=5) -> next cycle IDLE, all outputs 0, no done; a subsequent start redraws from (0,0).
